// File: rtl/permutation_scheduler.sv
// Round scheduler for the ASCON permutation. Owns the 320-bit state register
// and the round counter, feeds them to an external combinational round
// datapath and writes the datapath result back once per RUN cycle.

package permutation_scheduler_pkg;
  // Five 64-bit ASCON words, word 0 at index 0
  typedef logic [4:0][63:0] t_state_array;
endpackage

module permutation_scheduler
  import permutation_scheduler_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [3:0]   i_nb_rounds,
  input  t_state_array i_state,
  output logic [3:0]   o_round,
  output t_state_array o_round_state,
  input  t_state_array i_round_state,
  output t_state_array o_state,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [3:0] MAX_ROUNDS = 4'd12;
  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_reg;
  fsm_t         fsm_next;
  logic [3:0]   round_reg;
  logic [3:0]   round_next;
  t_state_array data_reg;
  t_state_array data_next;

  logic         start_ok;
  logic [3:0]   nb_clamped;

  // A request with zero rounds is not a request; anything above 12 runs as p12
  assign start_ok   = i_start && (i_nb_rounds != 4'd0);
  assign nb_clamped = (i_nb_rounds > MAX_ROUNDS) ? MAX_ROUNDS : i_nb_rounds;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (start_ok) fsm_next = RUN;
      RUN:     if (round_reg == LAST_ROUND) fsm_next = DONE;
      DONE:    fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // FSM outputs: one status flag per state
  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (fsm_reg)
      IDLE:    o_ready = 1'b1;
      RUN:     o_busy  = 1'b1;
      DONE:    o_done  = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  // Datapath next values: load on accept, step in RUN, hold otherwise
  always_comb begin
    round_next = round_reg;
    data_next  = data_reg;
    case (fsm_reg)
      IDLE: begin
        if (start_ok) begin
          // Start late in the constant schedule so the last round is always 11
          round_next = MAX_ROUNDS - nb_clamped;
          data_next  = i_state;
        end
      end
      RUN: begin
        data_next = i_round_state;
        // The counter parks at 11 on the final round so it never wraps
        if (round_reg != LAST_ROUND) begin
          round_next = round_reg + 4'd1;
        end
      end
      default: begin
        round_next = round_reg;
        data_next  = data_reg;
      end
    endcase
  end

  // Datapath registers: round counter and permutation state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      round_reg <= 4'd0;
      data_reg  <= '0;
    end else begin
      round_reg <= round_next;
      data_reg  <= data_next;
    end
  end

  assign o_round       = round_reg;
  assign o_round_state = data_reg;
  assign o_state       = data_reg;

endmodule

// File: tb/tb_permutation_scheduler.sv
// Randomized self-checking bench for permutation_scheduler. The round datapath
// is modelled here (golden ASCON round or a word-2 XOR stub) and expected
// results come from iterating the round rules over the scheduled constants.

module tb_permutation_scheduler;
  import permutation_scheduler_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         i_start;
  logic [3:0]   i_nb_rounds;
  t_state_array i_state;
  logic [3:0]   o_round;
  t_state_array o_round_state;
  t_state_array i_round_state;
  t_state_array o_state;
  logic         o_ready;
  logic         o_busy;
  logic         o_done;
  logic         stub_mode;

  int total;
  int bad;

  permutation_scheduler dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_nb_rounds   (i_nb_rounds),
    .i_state       (i_state),
    .o_round       (o_round),
    .o_round_state (o_round_state),
    .i_round_state (i_round_state),
    .o_state       (o_state),
    .o_ready       (o_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Golden ASCON round: constant addition, 5-bit S-box, linear diffusion
  function automatic t_state_array ascon_round(input t_state_array s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    t_state_array o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ {56'h0, 4'hf - r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
    return o;
  endfunction

  function automatic t_state_array stub_round(input t_state_array s, input logic [3:0] r);
    t_state_array o;
    o = s;
    o[2] = s[2] ^ {60'h0, r};
    return o;
  endfunction

  function automatic t_state_array rand_state();
    t_state_array s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  // Combinational round datapath the scheduler drives
  always_comb begin
    i_round_state = '0;
    if (stub_mode) i_round_state = stub_round(o_round_state, o_round);
    else           i_round_state = ascon_round(o_round_state, o_round);
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One full permutation: start, per-cycle RUN checks, completion and hold checks
  task automatic run_perm(input logic [3:0] nb, input t_state_array st, input logic m,
                          output t_state_array result);
    int n;
    t_state_array exp_s;
    n = (nb > 4'd12) ? 12 : int'(nb);
    exp_s = st;
    for (int r = 12 - n; r < 12; r++) begin
      exp_s = m ? stub_round(exp_s, 4'(r)) : ascon_round(exp_s, 4'(r));
    end
    result = exp_s;
    stub_mode = m;
    @(negedge clock);
    check("ready_before_start", 320'(o_ready), 320'(1));
    i_start = 1'b1;
    i_nb_rounds = nb;
    i_state = st;
    @(negedge clock);
    // Inputs after acceptance must not disturb the running permutation
    i_start = 1'b0;
    i_nb_rounds = 4'($urandom);
    i_state = rand_state();
    for (int r = 0; r < n; r++) begin
      check("run_busy", 320'(o_busy), 320'(1));
      check("run_round", 320'(o_round), 320'(12 - n + r));
      check("run_no_done", 320'(o_done), 320'(0));
      @(negedge clock);
    end
    check("done_pulse", 320'(o_done), 320'(1));
    check("done_not_busy", 320'(o_busy), 320'(0));
    check("done_state", 320'(o_state), 320'(exp_s));
    @(negedge clock);
    check("after_done_low", 320'(o_done), 320'(0));
    check("after_done_ready", 320'(o_ready), 320'(1));
    check("after_done_state", 320'(o_state), 320'(exp_s));
    $display("perm nb=%0d n=%0d stub=%0b result_w2=%h", nb, n, m, exp_s[2]);
  endtask

  initial begin
    t_state_array st;
    t_state_array last;
    logic prev_done;
    int p;
    total = 0;
    bad = 0;
    stub_mode = 1'b0;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_nb_rounds = 4'd0;
    i_state = '0;
    #1;
    check("reset_ready", 320'(o_ready), 320'(1));
    check("reset_busy", 320'(o_busy), 320'(0));
    check("reset_done", 320'(o_done), 320'(0));
    check("reset_round", 320'(o_round), 320'(0));
    check("reset_state", 320'(o_state), 320'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // p12 from the zero state through the golden round
    run_perm(4'd12, '0, 1'b0, last);

    // p6 through the stub: word 2 gets 6^7^..^11 = 1, other words untouched
    st = rand_state();
    run_perm(4'd6, st, 1'b1, last);
    check("p6_word2", 320'(last[2]), 320'(st[2] ^ 64'h1));
    check("p6_word0", 320'(last[0]), 320'(st[0]));

    // Zero rounds: start ignored, state held
    @(negedge clock);
    i_start = 1'b1;
    i_nb_rounds = 4'd0;
    i_state = rand_state();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("n0_ready", 320'(o_ready), 320'(1));
      check("n0_no_done", 320'(o_done), 320'(0));
      check("n0_state_held", 320'(o_state), 320'(last));
    end
    i_start = 1'b0;
    $display("n0 start ignored");

    // Over-range request clamps to p12
    run_perm(4'd15, rand_state(), 1'b0, last);

    // Start held high with n=8: runs repeat with a single IDLE gap
    stub_mode = 1'b1;
    @(negedge clock);
    i_start = 1'b1;
    i_nb_rounds = 4'd8;
    i_state = rand_state();
    prev_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      p = c % 10;
      check("held_ready", 320'(o_ready), 320'(p == 0));
      check("held_busy", 320'(o_busy), 320'(p >= 1 && p <= 8));
      check("held_done", 320'(o_done), 320'(p == 9));
      if (p >= 1 && p <= 8) check("held_round", 320'(o_round), 320'(p + 3));
      check("held_done_twice", 320'(prev_done & o_done), 320'(0));
      prev_done = o_done;
      @(negedge clock);
    end
    i_start = 1'b0;
    $display("held start: 2 runs checked");

    // Reset asserted during RUN cycle 3 of p12
    stub_mode = 1'b0;
    i_start = 1'b1;
    i_nb_rounds = 4'd12;
    i_state = rand_state();
    @(negedge clock);
    i_start = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_reset_round", 320'(o_round), 320'(2));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_ready", 320'(o_ready), 320'(1));
    check("async_busy", 320'(o_busy), 320'(0));
    check("async_done", 320'(o_done), 320'(0));
    check("async_round", 320'(o_round), 320'(0));
    check("async_state", 320'(o_state), 320'(0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      check("abort_no_done", 320'(o_done), 320'(0));
      check("abort_idle", 320'(o_ready), 320'(1));
    end
    $display("reset abort checked");
    st = rand_state();
    run_perm(4'd6, st, 1'b1, last);
    check("post_reset_p6_w2", 320'(last[2]), 320'(st[2] ^ 64'h1));

    // Randomized runs
    for (int k = 0; k < 10; k++) begin
      run_perm(4'($urandom_range(1, 15)), rand_state(), 1'($urandom_range(0, 1)), last);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
